// File: rtl/aes_core_ctrl_if.sv
//----------------------------------------------------------------------------
// aes_core_ctrl_if
//
// Host-side bus of the AES core controller. The host requests an operation
// with start, optionally forcing a fresh key expansion with keyLoad. The core
// reports progress with busy and a one-cycle done pulse. The ciphertext and
// the cycle count of the finished operation are returned on result and
// lastLatency.
//
// Signals
//   start        host -> core  request, sampled only while the core is idle
//   keyLoad      host -> core  demand fresh key expansion, sampled with start
//   key          host -> core  128-bit cipher key, captured on accepted start
//   blockIn      host -> core  128-bit plaintext, captured on accepted start
//   busy         core -> host  operation in progress
//   done         core -> host  one-cycle completion pulse
//   result       core -> host  128-bit ciphertext, held until the next done
//   lastLatency  core -> host  cycles from start acceptance to done, saturating
//
// Modports
//   master  host side (drives the request fields)
//   slave   core side (drives the status and result fields)
//----------------------------------------------------------------------------
interface aes_core_ctrl_if;
   logic         start;
   logic         keyLoad;
   logic [127:0] key;
   logic [127:0] blockIn;
   logic         busy;
   logic         done;
   logic [127:0] result;
   logic [7:0]   lastLatency;

   modport master (
      output start, keyLoad, key, blockIn,
      input  busy, done, result, lastLatency
   );

   modport slave (
      input  start, keyLoad, key, blockIn,
      output busy, done, result, lastLatency
   );
endinterface

// File: rtl/aes_core_ctrl.sv
//----------------------------------------------------------------------------
// aes_core_ctrl
//
// Sequencer for an AES encryption datapath made of a key-expansion block and
// an encryption block that share a single S-box. On an accepted host start
// the key and plaintext are registered and driven to the two blocks, the key
// expansion block is kicked with keyInit, and once it reports idle again the
// encryption block is kicked with encNext. When the encryption block reports
// idle the ciphertext is registered, done pulses for one cycle and the
// operation latency is published.
//
// Optional feature (macro KEY_CACHE_EN)
//   When defined, a start with keyLoad=0 after a completed key expansion
//   reuses the expanded key and goes straight to encryption. When undefined,
//   keyLoad is ignored and every start expands the key.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   host         host bus (aes_core_ctrl_if.slave)
//   keyOut       registered key to the key-expansion block
//   encBlock     registered plaintext to the encryption block
//   keyInit      one-cycle start pulse to the key-expansion block
//   encNext      one-cycle start pulse to the encryption block
//   keyReady     key-expansion block idle flag
//   encReady     encryption block idle flag
//   encResult    encryption block output
//   keySBoxReq   S-box request from the key-expansion block
//   encSBoxReq   S-box request from the encryption block
//   sBoxRequest  request forwarded to the shared S-box
//----------------------------------------------------------------------------
module aes_core_ctrl (
   input  logic                  clk,
   input  logic                  reset,
   aes_core_ctrl_if.slave        host,
   output logic [127:0]          keyOut,
   output logic [127:0]          encBlock,
   output logic                  keyInit,
   output logic                  encNext,
   input  logic                  keyReady,
   input  logic                  encReady,
   input  logic [127:0]          encResult,
   input  logic [31:0]           keySBoxReq,
   input  logic [31:0]           encSBoxReq,
   output logic [31:0]           sBoxRequest
);

   localparam int DATA_W = 128;
   localparam int LAT_W  = 8;

   typedef enum logic [2:0] {
      IDLE,
      KEY_START,
      KEY_WAIT,
      ENC_START,
      ENC_WAIT,
      FINISH
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   key_q, key_d;
   logic [DATA_W-1:0]   block_q, block_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [LAT_W-1:0]    last_lat_q, last_lat_d;
   logic                sbox_key_q, sbox_key_d;
   logic                busy_w;
   logic                done_w;
   logic                accept_w;
   logic                skip_key_w;

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
      if (v == {LAT_W{1'b1}}) begin
         return v;
      end
      return v + 1'b1;
   endfunction

   assign accept_w = (state_q == IDLE) && host.start;

`ifdef KEY_CACHE_EN
   logic key_valid_q, key_valid_d;

   // The expanded key is distrusted as soon as a new expansion is launched
   // and trusted again only when that expansion completes.
   always_comb begin
      key_valid_d = key_valid_q;
      if (accept_w && !skip_key_w) begin
         key_valid_d = 1'b0;
      end else if ((state_q == KEY_WAIT) && keyReady) begin
         key_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_valid_q <= 1'b0;
      end else begin
         key_valid_q <= key_valid_d;
      end
   end

   assign skip_key_w = !host.keyLoad && key_valid_q;
`else
   logic unused_keyload;
   assign unused_keyload = host.keyLoad;
   assign skip_key_w     = 1'b0;
`endif

   // Next-state and output decode
   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      block_d    = block_q;
      result_d   = result_q;
      lat_d      = lat_q;
      last_lat_d = last_lat_q;
      keyInit    = 1'b0;
      encNext    = 1'b0;
      busy_w     = 1'b0;
      done_w     = 1'b0;

      case (state_q)
         IDLE: begin
            if (host.start) begin
               key_d   = host.key;
               block_d = host.blockIn;
               lat_d   = '0;
               state_d = skip_key_w ? ENC_START : KEY_START;
            end
         end
         KEY_START: begin
            busy_w  = 1'b1;
            keyInit = 1'b1;
            lat_d   = sat_inc(lat_q);
            state_d = KEY_WAIT;
         end
         KEY_WAIT: begin
            busy_w = 1'b1;
            lat_d  = sat_inc(lat_q);
            if (keyReady) begin
               state_d = ENC_START;
            end
         end
         ENC_START: begin
            busy_w  = 1'b1;
            encNext = 1'b1;
            lat_d   = sat_inc(lat_q);
            state_d = ENC_WAIT;
         end
         ENC_WAIT: begin
            busy_w = 1'b1;
            lat_d  = sat_inc(lat_q);
            if (encReady) begin
               result_d   = encResult;
               // Published together with the result so it is valid at done;
               // the value counts every busy cycle including this one.
               last_lat_d = sat_inc(lat_q);
               state_d    = FINISH;
            end
         end
         FINISH: begin
            done_w  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // S-box ownership follows the upcoming state so that the registered
      // select lines up with the state register and never sees start directly.
      sbox_key_d = (state_d == KEY_START) || (state_d == KEY_WAIT);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         key_q      <= '0;
         block_q    <= '0;
         result_q   <= '0;
         lat_q      <= '0;
         last_lat_q <= '0;
         sbox_key_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         block_q    <= block_d;
         result_q   <= result_d;
         lat_q      <= lat_d;
         last_lat_q <= last_lat_d;
         sbox_key_q <= sbox_key_d;
      end
   end

   assign keyOut           = key_q;
   assign encBlock         = block_q;
   assign sBoxRequest      = sbox_key_q ? keySBoxReq : encSBoxReq;
   assign host.busy        = busy_w;
   assign host.done        = done_w;
   assign host.result      = result_q;
   assign host.lastLatency = last_lat_q;

endmodule

// File: tb/tb_aes_core_ctrl.sv
module tb_aes_core_ctrl;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [31:0]  KS = 32'hAAAA5555;
   localparam logic [31:0]  ES = 32'h5555AAAA;
   localparam int           KEY_LAT = 3;

   logic         clk;
   logic         reset;
   logic [127:0] keyOut, encBlock, encResult;
   logic         keyInit, encNext, keyReady, encReady;
   logic [31:0]  keySBoxReq, encSBoxReq, sBoxRequest;

   int enc_lat;
   int kcnt, ecnt;
   int n_cmp, n_bad;
   int n_keyinit, n_encnext, n_done, n_overlap, n_keychg, n_sbox_bad, n_kw;
   logic         in_kw, prev_busy, own;
   logic [127:0] prev_key;

   aes_core_ctrl_if hif ();

   aes_core_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .host        (hif),
      .keyOut      (keyOut),
      .encBlock    (encBlock),
      .keyInit     (keyInit),
      .encNext     (encNext),
      .keyReady    (keyReady),
      .encReady    (encReady),
      .encResult   (encResult),
      .keySBoxReq  (keySBoxReq),
      .encSBoxReq  (encSBoxReq),
      .sBoxRequest (sBoxRequest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign keySBoxReq = KS;
   assign encSBoxReq = ES;

   // Encryption block stand-in: known-answer table for the two test vectors.
   function automatic logic [127:0] enc_model(input logic [127:0] k, input logic [127:0] b);
      if (k == K1 && b == P1) return C1;
      if (k == K2 && b == P2) return C2;
      return 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
   endfunction
   assign encResult = enc_model(keyOut, encBlock);

   // Key-expansion block stand-in
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         keyReady <= 1'b1;
         kcnt     <= 0;
      end else if (keyInit) begin
         keyReady <= 1'b0;
         kcnt     <= KEY_LAT;
      end else if (!keyReady) begin
         if (kcnt <= 1) keyReady <= 1'b1;
         else kcnt <= kcnt - 1;
      end
   end

   // Encryption block stand-in
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         encReady <= 1'b1;
         ecnt     <= 0;
      end else if (encNext) begin
         encReady <= 1'b0;
         ecnt     <= enc_lat;
      end else if (!encReady) begin
         if (ecnt <= 1) encReady <= 1'b1;
         else ecnt <= ecnt - 1;
      end
   end

   // Running event counters and S-box ownership tracking
   initial begin
      n_keyinit = 0; n_encnext = 0; n_done = 0; n_overlap = 0;
      n_keychg = 0; n_sbox_bad = 0; n_kw = 0;
      in_kw = 1'b0; prev_busy = 1'b0; prev_key = '0;
   end

   always @(negedge clk) begin
      if (keyInit) n_keyinit++;
      if (encNext) n_encnext++;
      if (hif.done) n_done++;
      if (keyInit && encNext) n_overlap++;
      if (prev_busy && hif.busy && keyOut !== prev_key) n_keychg++;
      own = keyInit || in_kw;
      if (sBoxRequest !== (own ? KS : ES)) n_sbox_bad++;
      if (in_kw) n_kw++;
      if (!reset) in_kw = 1'b0;
      else if (keyInit) in_kw = 1'b1;
      else if (in_kw && keyReady) in_kw = 1'b0;
      prev_key  = keyOut;
      prev_busy = hif.busy;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Launch one operation from a negedge; returns at the negedge of the done
   // cycle (or after the cycle budget runs out).
   task automatic run_op(input logic [127:0] k, input logic [127:0] b, input logic kl,
                         input logic hammer, input int budget);
      hif.start   = 1'b1;
      hif.keyLoad = kl;
      hif.key     = k;
      hif.blockIn = b;
      @(negedge clk);
      chk("busy_after_accept", {127'd0, hif.busy}, 128'd1);
      if (hammer) begin
         hif.key     = ~k;
         hif.blockIn = ~b;
      end else begin
         hif.start = 1'b0;
      end
      for (int i = 0; i < budget; i++) begin
         if (hif.done) break;
         @(negedge clk);
      end
      chk("done_seen", {127'd0, hif.done}, 128'd1);
      hif.start = 1'b0;
   endtask

   int b_ki, b_en, b_dn;
   int exp_ki, exp_lat;

   initial begin
      n_cmp = 0; n_bad = 0;
      enc_lat = 5;
      reset = 1'b0;
      hif.start = 1'b0; hif.keyLoad = 1'b0; hif.key = '0; hif.blockIn = '0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_busy",     {127'd0, hif.busy}, 128'd0);
      chk("rst_done",     {127'd0, hif.done}, 128'd0);
      chk("rst_keyInit",  {127'd0, keyInit},  128'd0);
      chk("rst_encNext",  {127'd0, encNext},  128'd0);
      chk("rst_result",   hif.result, 128'd0);
      chk("rst_keyOut",   keyOut,     128'd0);
      chk("rst_encBlock", encBlock,   128'd0);
      chk("rst_lastLat",  {120'd0, hif.lastLatency}, 128'd0);
      chk("rst_sbox",     {96'd0, sBoxRequest}, {96'd0, ES});
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Known-answer vector with forced key expansion
      b_ki = n_keyinit; b_en = n_encnext; b_dn = n_done;
      run_op(K1, P1, 1'b1, 1'b0, 100);
      chk("kat_result",  hif.result, C1);
      chk("kat_latency", {120'd0, hif.lastLatency}, 128'd12);
      chk("kat_busy_at_done", {127'd0, hif.busy}, 128'd0);
      chk("kat_keyOut",  keyOut,   K1);
      chk("kat_encBlock", encBlock, P1);
      @(negedge clk);
      chk("done_one_cycle", {127'd0, hif.done}, 128'd0);
      @(negedge clk);
      chk("kat_keyInit_cnt", 128'(n_keyinit - b_ki), 128'd1);
      chk("kat_encNext_cnt", 128'(n_encnext - b_en), 128'd1);
      chk("kat_done_cnt",    128'(n_done - b_dn),    128'd1);

      // Same key, keyLoad=0
`ifdef KEY_CACHE_EN
      exp_ki = 0; exp_lat = 7;
`else
      exp_ki = 1; exp_lat = 12;
`endif
      b_ki = n_keyinit;
      run_op(K1, P1, 1'b0, 1'b0, 100);
      chk("cache_result",  hif.result, C1);
      chk("cache_latency", {120'd0, hif.lastLatency}, 128'(exp_lat));
      repeat (2) @(negedge clk);
      chk("cache_keyInit_cnt", 128'(n_keyinit - b_ki), 128'(exp_ki));

      // Start held high throughout, host key/block changed while busy
      b_ki = n_keyinit; b_en = n_encnext; b_dn = n_done;
      run_op(K2, P2, 1'b1, 1'b1, 100);
      chk("hammer_result",  hif.result, C2);
      chk("hammer_latency", {120'd0, hif.lastLatency}, 128'd12);
      chk("hammer_keyOut",  keyOut, K2);
      repeat (3) @(negedge clk);
      chk("hammer_busy_idle",   {127'd0, hif.busy}, 128'd0);
      chk("hammer_done_cnt",    128'(n_done - b_dn),    128'd1);
      chk("hammer_encNext_cnt", 128'(n_encnext - b_en), 128'd1);
      chk("hammer_keyInit_cnt", 128'(n_keyinit - b_ki), 128'd1);
      chk("hammer_keyOut_stable", 128'(n_keychg), 128'd0);

      // Reset in ENC_WAIT
      hif.start = 1'b1; hif.keyLoad = 1'b1; hif.key = K1; hif.blockIn = P1;
      @(negedge clk);
      hif.start = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (encNext) break;
         @(negedge clk);
      end
      chk("abort_encNext_seen", {127'd0, encNext}, 128'd1);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort_busy_async", {127'd0, hif.busy}, 128'd0);
      @(negedge clk);
      chk("abort_keyOut",   keyOut,     128'd0);
      chk("abort_encBlock", encBlock,   128'd0);
      chk("abort_result",   hif.result, 128'd0);
      chk("abort_lastLat",  {120'd0, hif.lastLatency}, 128'd0);
      chk("abort_done",     {127'd0, hif.done}, 128'd0);
      chk("abort_encNext",  {127'd0, encNext},  128'd0);
      chk("abort_sbox",     {96'd0, sBoxRequest}, {96'd0, ES});
      reset = 1'b1;
      repeat (2) @(negedge clk);
      b_ki = n_keyinit;
      run_op(K2, P2, 1'b0, 1'b0, 100);
      chk("post_rst_result",  hif.result, C2);
      chk("post_rst_latency", {120'd0, hif.lastLatency}, 128'd12);
      repeat (2) @(negedge clk);
      chk("post_rst_keyInit_cnt", 128'(n_keyinit - b_ki), 128'd1);

      // Latency saturation
      enc_lat = 300;
      run_op(K2, P2, 1'b1, 1'b0, 400);
      chk("sat_latency", {120'd0, hif.lastLatency}, 128'hFF);
      chk("sat_result",  hif.result, C2);
      enc_lat = 5;
      repeat (2) @(negedge clk);

      // Whole-run invariants
      chk("no_pulse_overlap", 128'(n_overlap), 128'd0);
      chk("sbox_owner",       128'(n_sbox_bad), 128'd0);
      chk("key_wait_exercised", {127'd0, (n_kw > 0)}, 128'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
